// File: rtl/contrast_pkg.sv
// Shared definitions for the contrast-stretching datapath: default pixel width
// and the IDLE/OP/LAST state encoding used by the multiplier, divider and top.
package contrast_pkg;

  localparam int DATA_WIDTH_DEF = 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OP   = 2'd1;
  localparam logic [1:0] LAST = 2'd2;

endpackage

// File: rtl/restoring_divider_unsigned_if.sv
// Start/operand/result bundle between the contrast top (master) and the
// restoring divider (slave).
interface restoring_divider_unsigned_if
  import contrast_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

  logic                      en_i_div;
  logic [2*DATA_WIDTH-1:0]   Q;
  logic [DATA_WIDTH-1:0]     B;
  logic [2*DATA_WIDTH-1:0]   quotient_o_div;
  logic [DATA_WIDTH-1:0]     remainder_o_div;
  logic                      div_done_o;
  logic                      div_zero_o;
  logic                      busy_o;

  modport master (
    output en_i_div, Q, B,
    input  quotient_o_div, remainder_o_div, div_done_o, div_zero_o, busy_o
  );

  modport slave (
    input  en_i_div, Q, B,
    output quotient_o_div, remainder_o_div, div_done_o, div_zero_o, busy_o
  );

endinterface

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor and keep the difference if it fits.
module div_step
  import contrast_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic [DATA_WIDTH:0]   rem,
  input  logic                  dvd_bit,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH:0]   rem_next,
  output logic                  q_bit
);

  logic [DATA_WIDTH:0] trial;
  logic [DATA_WIDTH:0] diff;
  // The stored remainder is always below the divisor, so its top bit is zero.
  logic                rem_msb_unused;

  assign rem_msb_unused = rem[DATA_WIDTH];

  always_comb begin
    trial    = {rem[DATA_WIDTH-1:0], dvd_bit};
    diff     = trial - {1'b0, divisor};
    q_bit    = (trial >= {1'b0, divisor});
    rem_next = q_bit ? diff : trial;
  end

endmodule

// File: rtl/restoring_divider_unsigned.sv
// Multi-cycle unsigned restoring divider: 2*DATA_WIDTH-bit dividend by
// DATA_WIDTH-bit divisor, one quotient bit per clock, MSB first.
module restoring_divider_unsigned
  import contrast_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic clk_i_div,
  input  logic rst_i_div,
  restoring_divider_unsigned_if.slave div_if
);

  localparam int QW    = 2 * DATA_WIDTH;
  localparam int CNT_W = $clog2(QW) + 1;
  localparam logic [CNT_W-1:0] FINAL_STEP = CNT_W'(QW - 1);

  logic [1:0]            state;
  logic [CNT_W-1:0]      step_cnt;
  logic                  accept;

  logic [QW-1:0]         dvd_quo;
  logic [DATA_WIDTH-1:0] divisor;
  logic [DATA_WIDTH:0]   part_rem;
  logic [DATA_WIDTH:0]   rem_next;
  logic                  q_bit;

  logic [QW-1:0]         quot_r;
  logic [DATA_WIDTH-1:0] rem_r;
  logic                  done_r;
  logic                  zero_r;
  logic                  busy_r;

  assign accept = (state == IDLE) && div_if.en_i_div;

  div_step #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_step (
    .rem      (part_rem),
    .dvd_bit  (dvd_quo[QW-1]),
    .divisor  (divisor),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  // Operand capture and shift/subtract datapath; restarted by every accept.
  always_ff @(posedge clk_i_div) begin
    if (accept) begin
      dvd_quo  <= div_if.Q;
      divisor  <= div_if.B;
      part_rem <= '0;
    end else if (state == OP) begin
      dvd_quo  <= {dvd_quo[QW-2:0], q_bit};
      part_rem <= rem_next;
    end
  end

  // Sequencing and result registers; reset discards any in-flight divide.
  always_ff @(posedge clk_i_div) begin
    if (rst_i_div) begin
      state    <= IDLE;
      step_cnt <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      zero_r   <= 1'b0;
      quot_r   <= '0;
      rem_r    <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (div_if.en_i_div) begin
            busy_r   <= 1'b1;
            step_cnt <= '0;
            state    <= (div_if.B == '0) ? LAST : OP;
          end
        end
        OP: begin
          step_cnt <= step_cnt + 1'b1;
          if (step_cnt == FINAL_STEP) begin
            state <= LAST;
          end
        end
        LAST: begin
          state  <= IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b1;
          if (divisor == '0) begin
            quot_r <= '1;
            rem_r  <= '0;
            zero_r <= 1'b1;
          end else begin
            quot_r <= dvd_quo;
            rem_r  <= part_rem[DATA_WIDTH-1:0];
            zero_r <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign div_if.quotient_o_div  = quot_r;
  assign div_if.remainder_o_div = rem_r;
  assign div_if.div_done_o      = done_r;
  assign div_if.div_zero_o      = zero_r;
  assign div_if.busy_o          = busy_r;

endmodule

// File: tb/tb_restoring_divider_unsigned.sv
// Self-checking bench: cycle model with plain division for the 8-bit divider,
// directed literal vectors, and a randomised sweep of a 4-bit instance.
module tb_restoring_divider_unsigned;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_pass = 0;
  logic chk_on = 1'b0;

  restoring_divider_unsigned_if #(.DATA_WIDTH(8)) bus8();
  restoring_divider_unsigned_if #(.DATA_WIDTH(4)) bus4();

  restoring_divider_unsigned #(.DATA_WIDTH(8)) dut8 (
    .clk_i_div (clk),
    .rst_i_div (rst),
    .div_if    (bus8)
  );

  restoring_divider_unsigned #(.DATA_WIDTH(4)) dut4 (
    .clk_i_div (clk),
    .rst_i_div (rst),
    .div_if    (bus4)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  // Transaction-level model of the 8-bit unit: a busy latency, then Q/B and Q%B.
  logic        m_busy, m_done, m_zero;
  logic [15:0] m_q, cap_q;
  logic [7:0]  m_r, cap_b;
  int          m_left;

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_zero <= 1'b0;
      m_q    <= '0;
      m_r    <= '0;
      m_left <= 0;
    end else if (m_busy) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        if (cap_b == 8'd0) begin
          m_q    <= 16'hFFFF;
          m_r    <= 8'd0;
          m_zero <= 1'b1;
        end else begin
          m_q    <= cap_q / {8'd0, cap_b};
          m_r    <= 8'(cap_q % {8'd0, cap_b});
          m_zero <= 1'b0;
        end
      end else begin
        m_done <= 1'b0;
      end
    end else begin
      m_done <= 1'b0;
      if (bus8.en_i_div) begin
        m_busy <= 1'b1;
        cap_q  <= bus8.Q;
        cap_b  <= bus8.B;
        m_left <= (bus8.B == 8'd0) ? 1 : 17;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("cyc_done", 32'(bus8.div_done_o), 32'(m_done));
      check("cyc_busy", 32'(bus8.busy_o), 32'(m_busy));
      check("cyc_zero", 32'(bus8.div_zero_o), 32'(m_zero));
      check("cyc_quot", 32'(bus8.quotient_o_div), 32'(m_q));
      check("cyc_rem",  32'(bus8.remainder_o_div), 32'(m_r));
    end
  end

  task automatic start8(input logic [15:0] q, input logic [7:0] b);
    @(negedge clk);
    bus8.en_i_div = 1'b1;
    bus8.Q        = q;
    bus8.B        = b;
    @(negedge clk);
    bus8.en_i_div = 1'b0;
  endtask

  task automatic wait_done8(input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus8.div_done_o && n < limit);
    if (!bus8.div_done_o) begin
      n_chk++;
      $display("FAIL done8_timeout: got no done, expected done within %0d cycles", limit);
      n = -1;
    end
  endtask

  task automatic run8(input string nm, input logic [15:0] q, input logic [7:0] b, input int lat,
                      input logic [15:0] eq, input logic [7:0] er, input logic ez);
    int n;
    start8(q, b);
    wait_done8(40, n);
    check({nm, "_lat"},  32'(n), 32'(lat));
    check({nm, "_quot"}, 32'(bus8.quotient_o_div), 32'(eq));
    check({nm, "_rem"},  32'(bus8.remainder_o_div), 32'(er));
    check({nm, "_zero"}, 32'(bus8.div_zero_o), 32'(ez));
  endtask

  task automatic div4(input logic [7:0] q, input logic [3:0] b);
    int         n;
    int         el;
    logic [7:0] eq;
    logic [3:0] er;
    logic       ez;
    if (b == 4'd0) begin
      eq = 8'hFF; er = 4'd0; ez = 1'b1; el = 1;
    end else begin
      eq = q / {4'd0, b}; er = 4'(q % {4'd0, b}); ez = 1'b0; el = 9;
    end
    @(negedge clk);
    bus4.en_i_div = 1'b1;
    bus4.Q        = q;
    bus4.B        = b;
    @(negedge clk);
    bus4.en_i_div = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus4.div_done_o && n < 30);
    if (!bus4.div_done_o) begin
      n_chk++;
      $display("FAIL div4_timeout: got no done for %0d/%0d, expected done within 30 cycles", q, b);
    end else begin
      check("w4_lat",  32'(n), 32'(el));
      check("w4_quot", 32'(bus4.quotient_o_div), 32'(eq));
      check("w4_rem",  32'(bus4.remainder_o_div), 32'(er));
      check("w4_zero", 32'(bus4.div_zero_o), 32'(ez));
    end
  endtask

  initial begin
    int n;
    int dones;
    rst = 1'b1;
    bus8.en_i_div = 1'b0; bus8.Q = '0; bus8.B = '0;
    bus4.en_i_div = 1'b0; bus4.Q = '0; bus4.B = '0;
    @(negedge clk);
    chk_on = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_quot", 32'(bus8.quotient_o_div), 32'd0);
    check("rst_rem",  32'(bus8.remainder_o_div), 32'd0);
    check("rst_done", 32'(bus8.div_done_o), 32'd0);
    check("rst_zero", 32'(bus8.div_zero_o), 32'd0);
    check("rst_busy", 32'(bus8.busy_o), 32'd0);

    run8("40000_200", 16'd40000, 8'd200, 17, 16'd200,   8'd0, 1'b0);
    run8("1000_7",    16'd1000,  8'd7,   17, 16'd142,   8'd6, 1'b0);
    run8("5_10",      16'd5,     8'd10,  17, 16'd0,     8'd5, 1'b0);
    run8("65535_1",   16'd65535, 8'd1,   17, 16'd65535, 8'd0, 1'b0);
    run8("65025_255", 16'd65025, 8'd255, 17, 16'd255,   8'd0, 1'b0);
    run8("1234_0",    16'd1234,  8'd0,   1,  16'hFFFF,  8'd0, 1'b1);
    run8("after_zero",16'd1000,  8'd7,   17, 16'd142,   8'd6, 1'b0);

    // Reset lands on the sixth OP step of an in-flight divide.
    start8(16'd1000, 8'd7);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_quot", 32'(bus8.quotient_o_div), 32'd0);
    check("midrst_rem",  32'(bus8.remainder_o_div), 32'd0);
    check("midrst_busy", 32'(bus8.busy_o), 32'd0);
    check("midrst_zero", 32'(bus8.div_zero_o), 32'd0);
    dones = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus8.div_done_o) dones++;
    end
    check("midrst_no_done", 32'(dones), 32'd0);
    run8("post_rst", 16'd65025, 8'd255, 17, 16'd255, 8'd0, 1'b0);

    // Held start with operands changed mid-divide, then an automatic re-trigger.
    @(negedge clk);
    bus8.en_i_div = 1'b1;
    bus8.Q = 16'd1000;
    bus8.B = 8'd7;
    repeat (4) @(negedge clk);
    bus8.Q = 16'd5;
    bus8.B = 8'd10;
    wait_done8(40, n);
    check("held_quot", 32'(bus8.quotient_o_div), 32'd142);
    check("held_rem",  32'(bus8.remainder_o_div), 32'd6);
    @(negedge clk);
    bus8.en_i_div = 1'b0;
    wait_done8(40, n);
    check("b2b_spacing", 32'(n + 1), 32'd18);
    check("b2b_quot", 32'(bus8.quotient_o_div), 32'd0);
    check("b2b_rem",  32'(bus8.remainder_o_div), 32'd5);
    repeat (3) @(negedge clk);

    div4(8'd255, 4'd0);
    div4(8'd255, 4'd1);
    div4(8'd255, 4'd15);
    div4(8'd0,   4'd3);
    div4(8'd14,  4'd15);
    for (int i = 0; i < 300; i++) begin
      div4(8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)));
    end

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
